// File: rtl/twiddle_gen_pipe_pkg.sv
// Shared defaults and elaboration-time helpers for the radix-4 twiddle generator.
// The octant table is computed from these helpers when the design is elaborated, so it follows N and TW_WID.
package twiddle_gen_pipe_pkg;

  localparam int DEF_LOG4N   = 4;
  localparam int DEF_TW_WID  = 21;
  localparam int DEF_STG_WID = 2;
  localparam int DEF_GRP_WID = 2*DEF_LOG4N - 2;

  localparam real PI = 3.14159265358979323846;

  typedef enum logic [1:0] {QUAD_0, QUAD_1, QUAD_2, QUAD_3} quadrant_e;

  // Taylor series for cos (odd_terms=0) or sin (odd_terms=1); the argument never exceeds pi/4.
  function automatic real series(real x, bit odd_terms);
    real term;
    real sum;
    term = odd_terms ? x : 1.0;
    sum  = term;
    for (int k = 1; k <= 12; k++) begin
      if (odd_terms)
        term = -term * x * x / $itor((2*k) * (2*k + 1));
      else
        term = -term * x * x / $itor((2*k - 1) * (2*k));
      sum = sum + term;
    end
    return sum;
  endfunction

  function automatic int round_away(real v);
    if (v >= 0.0)
      return $rtoi(v + 0.5);
    else
      return -$rtoi(0.5 - v);
  endfunction

  function automatic real rom_angle(int m, int n);
    return 2.0 * PI * $itor(m) / $itor(n);
  endfunction

  function automatic int rom_re_val(int m, int n, int tw_wid);
    int full;
    int v;
    full = (1 << (tw_wid - 1)) - 1;
    v    = round_away(series(rom_angle(m, n), 1'b0) * $itor(full));
    return (v > full) ? full : v;
  endfunction

  function automatic int rom_im_val(int m, int n, int tw_wid);
    int full;
    int v;
    full = (1 << (tw_wid - 1)) - 1;
    v    = -round_away(series(rom_angle(m, n), 1'b1) * $itor(full));
    return (v > full) ? full : v;
  endfunction

endpackage

// File: rtl/twiddle_gen_pipe_rom.sv
// One-octant cos/-sin table (N/8+1 entries) with a registered, one-cycle read.
module twiddle_octant_rom
  import twiddle_gen_pipe_pkg::*;
#(
  parameter int LOG4N  = DEF_LOG4N,
  parameter int TW_WID = DEF_TW_WID
)(
  input  logic                     clk,
  input  logic [2*LOG4N-3:0]       addr,
  output logic signed [TW_WID-1:0] re,
  output logic signed [TW_WID-1:0] im
);

  localparam int N     = 1 << (2*LOG4N);
  localparam int DEPTH = N/8 + 1;

  logic signed [TW_WID-1:0] tab_re [DEPTH];
  logic signed [TW_WID-1:0] tab_im [DEPTH];

  for (genvar m = 0; m < DEPTH; m++) begin : g_entry
    localparam logic signed [TW_WID-1:0] ENTRY_RE = TW_WID'(rom_re_val(m, N, TW_WID));
    localparam logic signed [TW_WID-1:0] ENTRY_IM = TW_WID'(rom_im_val(m, N, TW_WID));
    assign tab_re[m] = ENTRY_RE;
    assign tab_im[m] = ENTRY_IM;
  end

  always_ff @(posedge clk) begin
    re <= tab_re[addr];
    im <= tab_im[addr];
  end

endmodule

// File: rtl/twiddle_gen_pipe.sv
// Pipelined radix-4 twiddle generator: returns W^0, W^e, W^2e, W^3e per request, 3-cycle latency.
// Define TWIDDLE_CONJ_EN to let req_inverse conjugate the outputs for IFFT passes.
module twiddle_gen_pipe
  import twiddle_gen_pipe_pkg::*;
#(
  parameter int LOG4N   = DEF_LOG4N,
  parameter int TW_WID  = DEF_TW_WID,
  parameter int STG_WID = DEF_STG_WID,
  parameter int GRP_WID = DEF_GRP_WID
)(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [STG_WID-1:0]    req_stage,
  input  logic [GRP_WID-1:0]    req_group,
  input  logic                  req_inverse,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*TW_WID-1:0]   out_re,
  output logic [4*TW_WID-1:0]   out_im
);

  localparam int LOG2N = 2*LOG4N;
  localparam int N     = 1 << LOG2N;
  localparam int RWID  = LOG2N - 2;
  localparam logic signed [TW_WID-1:0] ONE      = TW_WID'((1 << (TW_WID - 1)) - 1);
  localparam logic [RWID-1:0]          HALF_OCT = RWID'(N/8);

  logic                        adv;
  logic [LOG2N-1:0]            grp_low;
  logic [LOG2N-1:0]            exp_e;
  logic                        v1;
  logic                        v2;
  logic [3:1][LOG2N-1:0]       p1;
  logic signed [TW_WID-1:0]    lane_re [1:3];
  logic signed [TW_WID-1:0]    lane_im [1:3];

  assign adv       = !(out_valid && !out_ready);
  assign req_ready = adv;

  // Late stages keep fewer group bits and scale them up; stages at or past the last give e = 0.
  always_comb begin
    grp_low = '0;
    for (int i = 0; i < GRP_WID; i++)
      if (i < 2*(LOG4N - 1 - int'(req_stage)))
        grp_low[i] = req_group[i];
    exp_e = grp_low << (2*int'(req_stage));
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      p1[1] <= exp_e;
      p1[2] <= exp_e << 1;
      p1[3] <= exp_e + (exp_e << 1);
    end
  end

`ifdef TWIDDLE_CONJ_EN
  logic inv1;
  logic inv2;

  always_ff @(posedge clk) begin
    if (adv) begin
      inv1 <= req_inverse;
      inv2 <= inv1;
    end
  end
`else
  logic unused_inverse;
  assign unused_inverse = req_inverse;
`endif

  for (genvar k = 1; k <= 3; k++) begin : g_lane
    logic [RWID-1:0]          r_k;
    logic [RWID-1:0]          addr_k;
    logic [RWID-1:0]          addr_sel;
    logic [RWID-1:0]          addr_hold;
    logic                     mirror_k;
    logic                     mirror2;
    quadrant_e                quad2;
    logic signed [TW_WID-1:0] rom_re;
    logic signed [TW_WID-1:0] rom_im;
    logic signed [TW_WID-1:0] a;
    logic signed [TW_WID-1:0] b;
    logic signed [TW_WID-1:0] rot_re;
    logic signed [TW_WID-1:0] rot_im;

    assign r_k      = p1[k][RWID-1:0];
    assign mirror_k = r_k > HALF_OCT;
    assign addr_k   = mirror_k ? -r_k : r_k;
    // The ROM has no enable, so on a stall it keeps re-reading the address it last served.
    assign addr_sel = adv ? addr_k : addr_hold;

    always_ff @(posedge clk) begin
      addr_hold <= addr_sel;
      if (adv) begin
        mirror2 <= mirror_k;
        quad2   <= quadrant_e'(p1[k][LOG2N-1 -: 2]);
      end
    end

    twiddle_octant_rom #(
      .LOG4N  (LOG4N),
      .TW_WID (TW_WID)
    ) u_rom (
      .clk  (clk),
      .addr (addr_sel),
      .re   (rom_re),
      .im   (rom_im)
    );

    always_comb begin
      a      = mirror2 ? -rom_im : rom_re;
      b      = mirror2 ? -rom_re : rom_im;
      rot_re = a;
      rot_im = b;
      case (quad2)
        QUAD_0: begin rot_re = a;  rot_im = b;  end
        QUAD_1: begin rot_re = b;  rot_im = -a; end
        QUAD_2: begin rot_re = -a; rot_im = -b; end
        QUAD_3: begin rot_re = -b; rot_im = a;  end
      endcase
    end

    assign lane_re[k] = rot_re;
`ifdef TWIDDLE_CONJ_EN
    assign lane_im[k] = inv2 ? -rot_im : rot_im;
`else
    assign lane_im[k] = rot_im;
`endif
  end

  // Valid bits and outputs advance together, so bubbles travel with the data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
    end else if (adv) begin
      v1        <= req_valid;
      v2        <= v1;
      out_valid <= v2;
      out_re    <= {lane_re[3], lane_re[2], lane_re[1], ONE};
      out_im    <= {lane_im[3], lane_im[2], lane_im[1], {TW_WID{1'b0}}};
    end
  end

endmodule
